// File: rtl/instr_fetch_stage.sv
// IF stage of the 16-bit MIPS datapath: owns the PC, drives instruction memory, fills IF/ID.
// Optional FETCH_ALIGN_CHECK_EN forces redirect targets to even addresses and flags misalignment.
module instr_fetch_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [PC_W-1:0]    pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic               misalign_err,
`endif
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus2,
  output logic               if_id_valid,
  output logic [1:0]         fetch_state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pp2_q, pp2_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_inc;
  logic               redirect;
  logic [PC_W-1:0]    target_raw;
  logic [PC_W-1:0]    target;

  assign redirect   = jump | branch_taken;
  assign target_raw = jump ? jump_target : branch_target;
  assign pc_inc     = pc_q + PC_W'(PC_INC);

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign target       = {target_raw[PC_W-1:1], 1'b0};
  assign misalign_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (redirect && target_raw[0])
      err_q <= 1'b1;
  end
`else
  assign target = target_raw;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp2_d   = pp2_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = target;
      instr_d = '0;
      pp2_d   = '0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (flush) begin
      // BOOT never advances the PC, even when its edge also carries a flush
      instr_d = '0;
      pp2_d   = '0;
      valid_d = 1'b0;
      if (!stall && state_q != BOOT)
        pc_d = pc_inc;
      state_d = stall ? STALL : RUN;
    end else if (stall) begin
      state_d = STALL;
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else begin
      pc_d    = pc_inc;
      instr_d = imem_instr;
      pp2_d   = pc_inc;
      valid_d = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pp2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp2_q   <= pp2_d;
      valid_q <= valid_d;
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus2 = pp2_q;
  assign if_id_valid    = valid_q;
  assign fetch_state    = state_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage; define FETCH_ALIGN_CHECK_EN to cover the alignment option.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
  logic        err_obs;

  int checks = 0;
  int errors = 0;

  instr_fetch_stage #(
    .PC_W    (16),
    .INSTR_W (16),
    .RESET_PC(16'h0000),
    .PC_INC  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .pc            (pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign_err  (err_obs),
`endif
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid   (if_id_valid),
    .fetch_state   (fetch_state)
  );

`ifndef FETCH_ALIGN_CHECK_EN
  assign err_obs = 1'b0;
`endif

  // Big-endian memory: byte 2k = 0, byte 2k+1 = k (low 8 bits)
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [15:0] k;
    k = a >> 1;
    return {8'h00, k[7:0]};
  endfunction

  assign imem_instr = mem_rd(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic [1:0]  st;
    logic        err;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    check("pc", 32'(pc), 32'(e.pc));
    check("imem_addr", 32'(imem_addr), 32'(e.pc));
    check("if_id_instr", 32'(if_id_instr), 32'(e.instr));
    check("if_id_pc_plus2", 32'(if_id_pc_plus2), 32'(e.pp2));
    check("if_id_valid", 32'(if_id_valid), 32'(e.valid));
    check("fetch_state", 32'(fetch_state), 32'(e.st));
    check("misalign_err", 32'(err_obs), 32'(e.err));
  endtask

  task automatic model_reset();
    m.pc = 16'h0000; m.instr = '0; m.pp2 = '0; m.valid = 1'b0; m.st = 2'd0; m.err = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] tgt;
    tgt = jump ? jump_target : branch_target;
`ifdef FETCH_ALIGN_CHECK_EN
    if ((jump || branch_taken) && tgt[0]) m.err = 1'b1;
    tgt[0] = 1'b0;
`endif
    if (jump || branch_taken) begin
      m.pc = tgt; m.instr = '0; m.pp2 = '0; m.valid = 1'b0; m.st = 2'd1;
    end else if (flush) begin
      m.instr = '0; m.pp2 = '0; m.valid = 1'b0;
      if (!stall && m.st != 2'd0) m.pc = m.pc + 16'd2;
      m.st = stall ? 2'd2 : 2'd1;
    end else if (stall) begin
      m.st = 2'd2;
    end else if (m.st == 2'd0) begin
      m.st = 2'd1;
    end else begin
      m.instr = mem_rd(m.pc);
      m.pp2   = m.pc + 16'd2;
      m.valid = 1'b1;
      m.pc    = m.pc + 16'd2;
      m.st    = 2'd1;
    end
  endtask

  task automatic cyc(input logic s, input logic f, input logic b, input logic [15:0] bt,
                     input logic j, input logic [15:0] jt);
    exp_t e;
    stall = s; flush = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    model_edge();
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(e);
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare(m);
    rst = 1'b0;

    cyc(0, 0, 0, 0, 0, 0);                       // BOOT edge
    check("boot_pc", 32'(pc), 32'h0);
    check("boot_valid", 32'(if_id_valid), 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("seq_instr", 32'(if_id_instr), 32'(i));
      check("seq_pp2", 32'(if_id_pc_plus2), 32'(2 * i + 2));
    end

    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      check("stall_pc", 32'(pc), 32'h8);
      check("stall_instr", 32'(if_id_instr), 32'h3);
      check("stall_state", 32'(fetch_state), 32'h2);
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("unstall_instr", 32'(if_id_instr), 32'h4);

    cyc(1, 0, 1, 16'h0040, 0, 0);
    check("br_pc", 32'(pc), 32'h40);
    check("br_valid", 32'(if_id_valid), 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check("br_instr", 32'(if_id_instr), 32'h20);
    check("br_pp2", 32'(if_id_pc_plus2), 32'h42);

    cyc(0, 0, 1, 16'h0080, 1, 16'h0010);
    check("jmp_wins_pc", 32'(pc), 32'h10);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("flush_valid", 32'(if_id_valid), 32'h0);
    check("flush_pc", 32'(pc), 32'h14);

    cyc(0, 0, 0, 0, 1, 16'hFFFE);
    cyc(0, 0, 0, 0, 0, 0);
    check("wrap_pc", 32'(pc), 32'h0);
    check("wrap_pp2", 32'(if_id_pc_plus2), 32'h0);

    for (int unsigned i = 0; i < 200; i++)
      cyc(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0, 16'($urandom),
          ($urandom % 10) == 0, 16'($urandom));

    cyc(0, 0, 0, 0, 1, 16'h0100);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    stall = 1'b1;
    #2;
    rst = 1'b1;                                  // async reset mid-cycle, no edge
    #1;
    model_reset();
    compare(m);
    stall = 1'b0;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("post_rst_instr", 32'(if_id_instr), 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    cyc(0, 0, 0, 0, 1, 16'h0021);
    check("align_pc", 32'(pc), 32'h20);
    check("align_err", 32'(err_obs), 32'h1);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    check("align_sticky", 32'(err_obs), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- IF stage of the 16-bit MIPS datapath, directly upstream of the byte-addressed, big-endian 16-bit instruction memory.
- Owns the PC and drives the memory address combinationally.
- Captures the returned instruction into the IF/ID pipeline register consumed by decode.
- Handles stall, flush, and branch/jump redirect with a small control FSM.

Parameters:
- PC_W, 16, width of PC and memory address.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 2, bytes per instruction (address step).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard hold: freeze PC and IF/ID.
- flush  in  1  squash IF/ID contents (insert bubble).
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  PC_W  branch destination byte address.
- jump  in  1  redirect to jump_target.
- jump_target  in  PC_W  jump destination byte address.
- imem_addr  out  PC_W  address to instruction memory; combinationally equals pc.
- imem_instr  in  INSTR_W  instruction returned combinationally by memory.
- pc  out  PC_W  current fetch PC (registered).
- if_id_instr  out  INSTR_W  registered instruction to decode.
- if_id_pc_plus2  out  PC_W  registered fetch PC + PC_INC.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_state  out  2  FSM state: 0 BOOT, 1 RUN, 2 STALL.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, if_id_instr=0, if_id_pc_plus2=0, if_id_valid=0, fetch_state=BOOT. Reset mid-operation discards IF/ID and any pending redirect.
- Latency: memory read is combinational, so the instruction at pc appears in IF/ID one clock after pc is presented.
- Redirect: redirect = jump | branch_taken. If both are asserted, jump wins; target = jump ? jump_target : branch_target.
- Per-edge priority (all states): redirect > flush > stall > normal.
- Redirect edge: pc<=target, IF/ID cleared (instr=0, pc_plus2=0, valid=0), state<=RUN. Wins over a simultaneous stall or flush.
- Flush without redirect: IF/ID cleared. pc holds if stall=1, else pc<=pc+PC_INC.
- Stall without redirect or flush: pc and all IF/ID fields hold; state<=STALL.
- Normal edge in RUN or STALL (stall=0): pc<=pc+PC_INC, if_id_instr<=imem_instr, if_id_pc_plus2<=pc+PC_INC, if_id_valid<=1, state<=RUN.
- BOOT: lasts exactly one edge after reset deassertion. At that edge pc holds, IF/ID stays invalid, and state<=RUN. A redirect at that edge is honoured.
- Stall at the BOOT edge: state<=STALL, pc holds.
- Wrap-around: pc+PC_INC is computed modulo 2^PC_W, so 16'hFFFE -> 16'h0000 with no error.
- Target alignment: bit 0 of the target is used as given unless the optional feature is enabled.
- Outputs are never X after reset; imem_addr is purely combinational from pc.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - adds output misalign_err (1 bit), reset 0.
  - Any redirect with target[0]=1 loads target with bit 0 forced to 0.
  - misalign_err sets to 1 on that edge and is sticky until rst.
  - A misaligned pc can never occur.
- When undefined: the port is absent and the target is loaded unmodified.

Test Plan:
- Memory with byte 2k=0 and byte 2k+1=k; release reset -> BOOT for 1 edge, then if_id_instr = 0x0000, 0x0001, 0x0002 on successive edges; if_id_pc_plus2 = 2, 4, 6; valid=1.
- stall=1 for 3 cycles while pc=0x0008 -> pc, if_id_instr=0x0003 and fetch_state=STALL all hold; on release, next if_id_instr=0x0004.
- branch_taken=1, branch_target=0x0040, with stall=1 on the same edge -> pc=0x0040, if_id_valid=0. Next edge: if_id_instr=0x0020, if_id_pc_plus2=0x0042.
- jump=1 (0x0010) and branch_taken=1 (0x0080) on the same edge -> pc=0x0010. Then flush alone -> valid=0 and pc=0x0012.
- Redirect to 0xFFFE -> next pc=0x0000, if_id_pc_plus2=0x0000. Assert rst mid-stall -> all outputs zero/RESET_PC immediately, with no clock edge needed.
- With FETCH_ALIGN_CHECK_EN: jump_target=0x0021 -> pc=0x0020, misalign_err=1, and it stays 1 after further normal fetches until rst.
